// File: rtl/tiny_core.sv
// tiny_core: 64 x GF(3^594) word store with host port and a small
// A+B / A-B / -A engine; engine present only with TINY_ENGINE_EN defined.
module tiny_core #(
  parameter int M  = 593,
  parameter int DW = 2 * (M + 1),
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic [AW-1:0] addr,
  input  logic          w,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] out,
  output logic          done
);

  localparam int WIDTH_D0 = DW - 1;
  localparam int DEPTH    = 1 << AW;

  logic [WIDTH_D0:0] r_ram [DEPTH];

`ifdef TINY_ENGINE_EN
  localparam int ND = M + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LD0, S_LD1, S_WADD, S_WSUB, S_WNEG, S_DONE
  } state_t;

  state_t          r_state;
  logic            r_sel_d;
  logic            r_done;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   w_sum;
  logic [DW-1:0]   w_dif;
  logic [DW-1:0]   w_neg;
  logic            w_run;

  // 11 is a non-canonical zero
  function automatic logic [1:0] f_norm(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic [1:0] f_neg(input logic [1:0] d);
    logic [1:0] n;
    n = f_norm(d);
    return {n[0], n[1]};
  endfunction

  function automatic logic [1:0] f_add(input logic [1:0] a,
                                      input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, f_norm(a)} + {1'b0, f_norm(b)};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign w_run = reset & ~sel;
  assign done  = r_done;

  // digit-wise mod-3 results from the latched operands
  always_comb begin
    w_sum = '0;
    w_dif = '0;
    w_neg = '0;
    for (int i = 0; i < ND; i++) begin
      w_sum[2*i +: 2] = f_add(r_a[2*i +: 2], r_b[2*i +: 2]);
      w_dif[2*i +: 2] = f_add(r_a[2*i +: 2], f_neg(r_b[2*i +: 2]));
      w_neg[2*i +: 2] = f_neg(r_a[2*i +: 2]);
    end
  end

  // previous sel, for detecting the host release edge
  always_ff @(posedge clk) begin
    r_sel_d <= sel;
  end

  // engine sequencer; sel=1 aborts or acknowledges done
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else if (sel) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (r_sel_d) r_state <= S_LD0;
        S_LD0: begin
          r_a     <= r_ram[0];
          r_state <= S_LD1;
        end
        S_LD1: begin
          r_b     <= r_ram[1];
          r_state <= S_WADD;
        end
        S_WADD: r_state <= S_WSUB;
        S_WSUB: r_state <= S_WNEG;
        S_WNEG: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: r_done <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign done = 1'b0;
`endif

  // host writes, plus engine result writes while the host is away
  always_ff @(posedge clk) begin
    if (sel && w) begin
      r_ram[addr] <= data;
    end
`ifdef TINY_ENGINE_EN
    else if (w_run) begin
      unique case (r_state)
        S_WADD:  r_ram[2] <= w_sum;
        S_WSUB:  r_ram[3] <= w_dif;
        S_WNEG:  r_ram[4] <= w_neg;
        default: ;
      endcase
    end
`endif
  end

  // registered host read; out is never reset
  always_ff @(posedge clk) begin
    if (sel && !w) out <= r_ram[addr];
  end

`ifndef TINY_ENGINE_EN
  logic w_unused;
  assign w_unused = reset;
`endif

endmodule

// File: tb/tb_tiny_core.sv
// tb_tiny_core: directed checks of host port, engine results,
// abort and reset; expectations follow TINY_ENGINE_EN.
module tb_tiny_core;

  localparam int DW = 1188;
  localparam int AW = 6;
`ifdef TINY_ENGINE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          sel;
  logic [AW-1:0] addr;
  logic          w;
  logic [DW-1:0] data;
  logic [DW-1:0] out;
  logic          done;

  int n_cmp;
  int n_bad;

  logic [DW-1:0] V0, V3, D12, ALL0, ALL1, ALL2, ALL3;
  logic [DW-1:0] MK2, MK3, MK4, MK5, JUNK, ONE;

  tiny_core dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .addr (addr),
    .w    (w),
    .data (data),
    .out  (out),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    int fb;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      fb = -1;
      for (int i = 0; i < DW; i++)
        if (fb < 0 && got[i] !== exp[i]) fb = i;
      $display("FAIL %s: got[127:0]=%h exp[127:0]=%h first_bad_bit=%0d",
               tag, got[127:0], exp[127:0], fb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    sel  = 1'b1;
    w    = 1'b1;
    addr = AW'(a);
    data = d;
    tick();
  endtask

  task automatic rd_chk(input string tag, input int a,
                        input logic [DW-1:0] exp);
    sel  = 1'b1;
    w    = 1'b0;
    addr = AW'(a);
    tick();
    chk(tag, out, exp);
  endtask

  task automatic run_eng(input string tag);
    sel = 1'b0;
    w   = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk({tag, "_done5"}, DW'(done), '0);
    tick();
    chk({tag, "_done6"}, DW'(done), EN ? ONE : ALL0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    V0   = '0;
    V3   = '0;
    V0[197:0] = 198'h115a25886512165251569195908560596a6695612620504191;
    V3[197:0] = 198'h1559546442405a181195655549614540592955a15a26984015;
    D12  = '0;
    D12[197:0] = {2'b01, {49{4'h2}}};
    ALL0 = '0;
    ALL1 = {594{2'b01}};
    ALL2 = {594{2'b10}};
    ALL3 = '1;
    MK2  = {297{4'h9}};
    MK3  = {297{4'h6}};
    MK4  = {198{6'h21}};
    MK5  = {297{4'h4}};
    JUNK = {297{4'h1}};
    ONE  = DW'(1);

    reset = 1'b0;
    sel   = 1'b1;
    w     = 1'b0;
    addr  = '0;
    data  = '0;
    tick();
    tick();
    chk("rst_done", DW'(done), ALL0);

    wr(0, V0);
    wr(3, V3);
    data = D12;
    rd_chk("rd0", 0, V0);
    data = D12;
    rd_chk("rd3", 3, V3);
    wr(5, MK5);
    chk("wr_holds_out", out, V3);
    sel  = 1'b0;
    w    = 1'b1;
    addr = 5;
    data = JUNK;
    tick();
    chk("sel0_holds_out", out, V3);
    chk("rst_no_start", DW'(done), ALL0);

    reset = 1'b1;
    wr(0, ALL1);
    wr(1, ALL2);
    wr(2, MK2);
    wr(3, MK3);
    wr(4, MK4);
    run_eng("eng");
    rd_chk("eng_add", 2, EN ? ALL0 : MK2);
    chk("eng_ack_done", DW'(done), ALL0);
    rd_chk("eng_sub", 3, EN ? ALL2 : MK3);
    rd_chk("eng_neg", 4, EN ? ALL2 : MK4);
    rd_chk("sel0_no_write", 5, MK5);

    wr(0, ALL3);
    wr(1, ALL0);
    wr(2, MK2);
    wr(3, MK3);
    wr(4, MK4);
    run_eng("inv");
    rd_chk("inv_add", 2, EN ? ALL0 : MK2);
    rd_chk("inv_sub", 3, EN ? ALL0 : MK3);
    rd_chk("inv_neg", 4, EN ? ALL0 : MK4);

    wr(0, ALL1);
    wr(1, ALL2);
    wr(2, MK2);
    wr(3, MK3);
    wr(4, MK4);
    sel = 1'b0;
    w   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rd_chk("abort_add", 2, EN ? ALL0 : MK2);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_done", DW'(done), ALL0);
    rd_chk("abort_sub", 3, MK3);
    rd_chk("abort_neg", 4, MK4);

    run_eng("rst");
    reset = 1'b0;
    tick();
    chk("rst_in_done", DW'(done), ALL0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_no_restart", DW'(done), ALL0);
    reset = 1'b0;
    rd_chk("rst_host_rd", 3, EN ? ALL2 : MK3);
    reset = 1'b1;
    rd_chk("rst_host_rd2", 4, EN ? ALL2 : MK4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tiny_core.md
# tiny_core

Top-level storage and sequencing block of the GF(3^M) pairing datapath, M = 593. It holds a 64-entry register file of GF(3^594-digit) words that the host loads and reads through a single synchronous port. A small internal engine runs a fixed three-operation GF(3) micro-program on those words when the host releases the port.

## Interface
Parameters (compile-time constants):
- M, 593: field extension degree.
- DW, 1188: word width, 594 two-bit GF(3) digits; `WIDTH_D0` = DW-1 = 1187.
- AW, 6: address width, 64 entries.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; resets engine FSM and `done` only.
- sel  in  1  1 = host owns RAM port; 1→0 transition starts engine.
- addr  in  6  host word address.
- w  in  1  host write enable, qualified by `sel`.
- data  in  1188  host write data.
- out  out  1188  registered read data.
- done  out  1  engine finished; level.

## Operation
- Digit i = bits [2i+1:2i]; encoding 00=0, 01=1, 10=2; 11 is read as 0.
- RAM: 64 × 1188 bits, not cleared by reset. Contents are undefined at power-up.
- Host write: rising edge with sel=1, w=1 writes RAM[addr] ← data. The write occurs regardless of the level of `reset`.
- Host read: rising edge with sel=1, w=0 loads out ← RAM[addr] (old contents).
- With sel=1, w=1, `out` holds its value.
- sel=0: `out` holds its last value; host `w` is ignored.
- `out` is never cleared by reset.
- Engine FSM states: IDLE, LD0, LD1, WADD, WSUB, WNEG, DONE.
  - IDLE→LD0: rising edge where reset=1, sel=0 and sel was 1 on the previous edge.
  - LD0: latch A ← RAM[0].
  - LD1: latch B ← RAM[1].
  - WADD: RAM[2] ← A+B, digit-wise mod 3.
  - WSUB: RAM[3] ← A−B, digit-wise mod 3.
  - WNEG: RAM[4] ← −A, digit-wise mod 3.
  - WNEG→DONE.
  - DONE: done=1; stays in DONE until sel=1, which returns it to IDLE with done=0 on the same edge.
- sel=1 in any state LD0..WNEG aborts to IDLE. RAM writes already performed are kept; no later write occurs.
- reset=0 forces IDLE, done=0 on that edge. The host port is unaffected.
- Results written by the engine are always canonical: no 11 digits.

## Timing
- Host write: one edge; data is readable on the next edge.
- Read latency: one clock. addr is presented before edge N; `out` is valid after edge N.
- Engine: start edge, then 5 edges (LD0..WNEG). done=1 after the 6th edge following the 1→0 edge of `sel`.
- done is registered and deasserts on the first edge with sel=1 or reset=0.

## Configuration
- TINY_ENGINE_EN defined: engine, FSM and `done` are as above.
- TINY_ENGINE_EN undefined: block is the RAM only. done is tied to 0, sel=0 does nothing, and RAM[2..4] change only through host writes.

## Test plan
- Hold reset=0, sel=1. Write RAM[0]=198'h115a25886512165251569195908560596a6695612620504191 and RAM[3]=198'h1559546442405a181195655549614540592955a15a26984015 (upper bits 0). Then apply w=0, data=198'h1222…2, addr=3. Read addr 0, then addr 3 → out matches the written values one clock after each address; RAM[3] is not overwritten.
- Engine run, reset=1, RAM[0]=digits all 1 (…5555), RAM[1]=digits all 2 (…aaaa). Drop sel → done=1 after 6 edges. Then RAM[2]=all 0, RAM[3]=all 2 (…aaaa), RAM[4]=all 2 (…aaaa).
- Invalid digits: RAM[0]=all 11, RAM[1]=0 → RAM[2]=RAM[3]=RAM[4]=0.
- Abort: raise sel during WSUB → RAM[2] is updated, RAM[3] and RAM[4] keep their old values, done stays 0.
- Reset: pull reset=0 while in DONE → done=0 next edge. Host read still returns RAM contents.
- With TINY_ENGINE_EN undefined: sel 1→0 → done stays 0 and RAM[2] is unchanged.
